inference_batch_scheduler: RTL

Single-clock sequencer driving the CNN→SNN inference pipeline over a batch of samples. For each sample it copies PIXELS bytes from an external sample memory into the CNN input BRAM, asserts a stretched start pulse, waits for inference completion with a timeout, and emits one result record per sample over a valid/ready port. It sits between the host/test harness and the top-level inference core's BRAM-load, start, done and class ports, and keeps per-class and timeout statistics for the batch.

---
 rtl/inference_batch_scheduler_if.sv | 41 ++++
 rtl/inference_batch_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inference_batch_scheduler_if.sv
// Signal bundle between the batch scheduler (master) and the host, sample
// memory, CNN input BRAM, inference core and result consumer (slave).
interface inference_batch_scheduler_if #(
    parameter int SMEM_AW = 16
);
    logic               i_batch_start;
    logic [7:0]         i_batch_count;
    logic               o_busy;
    logic [SMEM_AW-1:0] o_smem_addr;
    logic [7:0]         i_smem_rdata;
    logic               o_bram_we;
    logic [8:0]         o_bram_addr;
    logic [7:0]         o_bram_wdata;
    logic               o_start_inference;
    logic               i_inference_done;
    logic [1:0]         i_predicted_class;
    logic               o_result_valid;
    logic               i_result_ready;
    logic [7:0]         o_result_index;
    logic [1:0]         o_result_class;
    logic               o_result_timeout;
    logic [31:0]        o_class_hist;
    logic [7:0]         o_timeout_count;
    logic               o_batch_done;

    modport master (
        input  i_batch_start, i_batch_count, i_smem_rdata, i_inference_done,
               i_predicted_class, i_result_ready,
        output o_busy, o_smem_addr, o_bram_we, o_bram_addr, o_bram_wdata,
               o_start_inference, o_result_valid, o_result_index, o_result_class,
               o_result_timeout, o_class_hist, o_timeout_count, o_batch_done
    );

    modport slave (
        output i_batch_start, i_batch_count, i_smem_rdata, i_inference_done,
               i_predicted_class, i_result_ready,
        input  o_busy, o_smem_addr, o_bram_we, o_bram_addr, o_bram_wdata,
               o_start_inference, o_result_valid, o_result_index, o_result_class,
               o_result_timeout, o_class_hist, o_timeout_count, o_batch_done
    );
endinterface

// File: rtl/inference_batch_scheduler.sv
// Batch sequencer: loads each sample into the CNN input BRAM, kicks inference,
// waits for done (with timeout) and hands out one result record per sample.
module inference_batch_scheduler #(
    parameter int PIXELS         = 256,
    parameter int START_HOLD     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SMEM_AW        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    inference_batch_scheduler_if.master bus
);
    localparam int KW = 10;
    localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [KW-1:0]      K_LAST    = KW'(PIXELS);
    localparam logic [HW-1:0]      H_LAST    = HW'(START_HOLD - 1);
    localparam logic [TW-1:0]      T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SMEM_AW-1:0] BASE_STEP = SMEM_AW'(PIXELS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_RESULT, S_DONE
    } state_t;

    state_t             r_state;
    logic [KW-1:0]      r_k;
    logic [HW-1:0]      r_hold;
    logic [TW-1:0]      r_tmo;
    logic [7:0]         r_count;
    logic [7:0]         r_index;
    logic [SMEM_AW-1:0] r_base;
    logic               r_done_q;
    logic [7:0]         r_hist [4];
    logic [7:0]         r_timeout_count;
    logic               r_busy;
    logic [SMEM_AW-1:0] r_smem_addr;
    logic               r_bram_we;
    logic [8:0]         r_bram_addr;
    logic               r_start;
    logic               r_valid;
    logic [1:0]         r_class;
    logic               r_timeout;
    logic               r_batch_done;

    logic               w_done_edge;
    logic [KW-1:0]      w_k_next;

    assign w_done_edge = bus.i_inference_done & ~r_done_q;
    assign w_k_next    = r_k + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_k             <= '0;
            r_hold          <= '0;
            r_tmo           <= '0;
            r_count         <= '0;
            r_index         <= '0;
            r_base          <= '0;
            r_done_q        <= 1'b0;
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_timeout_count <= '0;
            r_busy          <= 1'b0;
            r_smem_addr     <= '0;
            r_bram_we       <= 1'b0;
            r_bram_addr     <= '0;
            r_start         <= 1'b0;
            r_valid         <= 1'b0;
            r_class         <= '0;
            r_timeout       <= 1'b0;
            r_batch_done    <= 1'b0;
        end else begin
            r_done_q     <= bus.i_inference_done;
            r_bram_we    <= 1'b0;
            r_batch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_batch_start) begin
                        r_count         <= bus.i_batch_count;
                        r_index         <= '0;
                        r_base          <= '0;
                        r_timeout_count <= '0;
                        for (int i = 0; i < 4; i++) r_hist[i] <= '0;
                        r_busy          <= 1'b1;
                        r_smem_addr     <= '0;
                        r_k             <= '0;
                        if (bus.i_batch_count == 8'd0) begin
                            r_batch_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                // Address for pixel k goes out in phase k; its data lands in phase k+1.
                S_LOAD: begin
                    if (r_k == K_LAST) begin
                        r_start <= 1'b1;
                        r_hold  <= '0;
                        r_state <= S_START;
                    end else begin
                        r_k         <= w_k_next;
                        r_bram_we   <= 1'b1;
                        r_bram_addr <= r_k[8:0];
                        if (w_k_next != K_LAST) r_smem_addr <= r_base + SMEM_AW'(w_k_next);
                    end
                end
                S_START: begin
                    if (r_hold == H_LAST) begin
                        r_start <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_done_edge) begin
                        r_class   <= bus.i_predicted_class;
                        r_timeout <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= S_RESULT;
                    end else if (r_tmo == T_LAST) begin
                        r_class   <= '0;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b1;
                        r_state   <= S_RESULT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (bus.i_result_ready) begin
                        r_valid <= 1'b0;
                        if (r_timeout) begin
                            if (r_timeout_count != 8'hFF) r_timeout_count <= r_timeout_count + 8'd1;
                        end else if (r_hist[r_class] != 8'hFF) begin
                            r_hist[r_class] <= r_hist[r_class] + 8'd1;
                        end
                        if (r_index == r_count - 8'd1) begin
                            r_batch_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_index     <= r_index + 8'd1;
                            r_base      <= r_base + BASE_STEP;
                            r_smem_addr <= r_base + BASE_STEP;
                            r_k         <= '0;
                            r_state     <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write data is the memory's registered read port passed straight through,
    // so it lines up with the registered write strobe without an extra stage.
    assign bus.o_bram_wdata      = r_bram_we ? bus.i_smem_rdata : 8'd0;
    assign bus.o_busy            = r_busy;
    assign bus.o_smem_addr       = r_smem_addr;
    assign bus.o_bram_we         = r_bram_we;
    assign bus.o_bram_addr       = r_bram_addr;
    assign bus.o_start_inference = r_start;
    assign bus.o_result_valid    = r_valid;
    assign bus.o_result_index    = r_index;
    assign bus.o_result_class    = r_class;
    assign bus.o_result_timeout  = r_timeout;
    assign bus.o_class_hist      = {r_hist[3], r_hist[2], r_hist[1], r_hist[0]};
    assign bus.o_timeout_count   = r_timeout_count;
    assign bus.o_batch_done      = r_batch_done;
endmodule
